// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: owns the write port while loading a program,
// then holds the PC and drives the read address while fetching.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              reload,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              halt_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] imem_raddr,
  output logic [31:0]       pc,
  output logic              fetch_valid,
  output logic              running,
  output logic              err_overflow,
  output logic              err_align,
  output logic              err_range
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                fv_q, fv_d;
  logic                ovf_q, ovf_d;
  logic                align_q, align_d;
  logic                range_q, range_d;
  logic [31:0]         nxt_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      align_q <= 1'b0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      fv_q    <= fv_d;
      ovf_q   <= ovf_d;
      align_q <= align_d;
      range_q <= range_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    align_d = align_q;
    range_d = range_q;
    nxt_pc  = pc_q;

    case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = load_data;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == '1) ovf_d = 1'b1;
        end
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN: begin
        if (branch_taken) begin
          nxt_pc = {branch_target[31:2], 2'b00};
          if (branch_target[1:0] != 2'b00) align_d = 1'b1;
        end else if (stall) begin
          nxt_pc = pc_q;
        end else begin
          nxt_pc = pc_q + 32'd4;
        end
        // An out-of-range next PC halts without committing it, ahead of halt_req.
        if (nxt_pc[31:ADDR_W+2] != '0) begin
          state_d = S_HALT;
          range_d = 1'b1;
        end else begin
          pc_d = nxt_pc;
          if (halt_req) state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (reload) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          pc_d    = RESET_PC;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_LOAD;
    endcase

    fv_d = (state_d == S_RUN);
  end

  assign load_ready   = (state_q == S_LOAD);
  assign running      = (state_q == S_RUN);
  assign fetch_valid  = fv_q;
  assign pc           = pc_q;
  assign imem_raddr   = pc_q[ADDR_W+1:2];
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign err_overflow = ovf_q;
  assign err_align    = align_q;
  assign err_range    = range_q;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and port owner for the 1024-word instruction memory. It owns the memory's write port during program load and drives the word read address during execution. It also holds the program counter: sequential advance, pipeline stall, branch redirect, halt and restart. It sits between the instruction memory and the IF/ID pipeline register, replacing the free-running PC register.

## Interface
- ADDR_W, 10, word-address width of instruction memory (depth 2^ADDR_W)
- RESET_PC, 32'h0000_0000, PC value after reset and after each reload; must be word-aligned

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  loader presents a program word
- load_data  in  32  program word
- load_ready  out  1  word accepted when load_valid && load_ready
- start  in  1  leave LOAD/HALT and begin fetching
- reload  in  1  from HALT only: return to LOAD, load pointer cleared
- stall  in  1  hazard unit freezes PC
- branch_taken  in  1  redirect request from EX/MEM
- branch_target  in  32  redirect byte address
- halt_req  in  1  stop fetching after current cycle
- imem_we  out  1  memory write strobe
- imem_waddr  out  ADDR_W  memory write word address
- imem_wdata  out  32  memory write data
- imem_raddr  out  ADDR_W  memory read word address, = pc[ADDR_W+1:2]
- pc  out  32  current fetch byte address
- fetch_valid  out  1  word at imem_raddr is a real fetch
- running  out  1  state == RUN
- err_overflow  out  1  sticky: load beat written at last address then wrapped
- err_align  out  1  sticky: branch_target[1:0] != 0 seen
- err_range  out  1  sticky: pc reached 4*2^ADDR_W

## Operation
- States: LOAD, RUN, HALT. Reset -> LOAD.
- Reset values: pc=RESET_PC, load_ptr=0, imem_we=0, imem_waddr=0, imem_wdata=0, fetch_valid=0, running=0, all err flags 0. load_ready=1 once in LOAD.
- LOAD:
  - load_ready=1.
  - Each accepted beat registers imem_we=1, imem_waddr=load_ptr, imem_wdata=load_data, then increments load_ptr.
  - load_ptr wraps 2^ADDR_W-1 -> 0 and sets err_overflow.
  - start -> RUN with pc=RESET_PC. A beat accepted in the same cycle as start is still written.
- RUN:
  - load_ready=0, fetch_valid=1, running=1.
  - Next-PC priority: branch_taken > stall > pc+4. Branch overrides stall.
  - branch_target low two bits are cleared before use; a nonzero value sets err_align.
  - halt_req -> HALT; pc keeps the value it would have taken this cycle. halt_req wins over nothing else.
  - If next pc >= 4*2^ADDR_W: state -> HALT, pc is not updated, err_range is set.
- HALT:
  - fetch_valid=0, running=0, pc frozen.
  - start -> RUN, resuming at the current pc.
  - reload -> LOAD with load_ptr=0 and pc=RESET_PC. If start and reload are both asserted, reload wins.
- start, reload and stall are ignored in states where they are not listed above.
- Error flags clear only on reset.

## Timing
- pc, state, fetch_valid and the write-port outputs are all registered.
- imem_raddr is combinational from pc. The memory read is combinational, so the instruction for pc is valid in the same cycle as pc.
- Write latency: accepted beat at edge N appears on imem_we/waddr/wdata during cycle N+1; imem_we is a single-cycle pulse per beat.
- Back-to-back beats give one write per cycle.
- Branch: branch_taken sampled at edge N; pc=target from edge N onward; fetch_valid stays 1.
- Stall: pc holds while stall=1; releases on the first edge with stall=0.
- LOAD->RUN: the first fetch (pc=RESET_PC, fetch_valid=1) occurs in the cycle after the start edge.
- Reset has priority over everything, including mid-load and mid-branch. A write pending from the previous edge is dropped: imem_we=0 after the reset edge.

## Test plan
- Reset, load 7 words 0x01095020..0xAC0A0000, then start -> imem_we pulses at addresses 0..6 with the matching data; first RUN cycle pc=0; pc steps 0,4,8,…
- RUN with stall held 3 cycles at pc=8 -> pc stays 8 for 3 cycles, then 12.
- branch_taken=1 with target=0x4 while stall=1 at pc=0x14 -> next pc=0x4. A second branch with target=0x6 -> pc=0x4 and err_align=1.
- Load 1025 beats with ADDR_W=10 -> the last beat writes address 0 and err_overflow=1.
- RUN to pc=0xFFC -> next edge gives HALT, pc=0xFFC, err_range=1, fetch_valid=0. Then reload -> LOAD, load_ready=1, pc=0.
- halt_req at pc=0x10, then start two cycles later -> fetch resumes at pc=0x14. Reset asserted mid-load -> imem_we=0 and load_ptr=0 on the next cycle.
